// File: rtl/mips_decode_stage.sv
// mips_decode_stage: registered instruction-decode stage between IF and EX of a 5-stage MIPS pipeline.
// Latency: accept at edge N, decoded instruction presented from cycle N+1 (a load-use bubble adds one cycle).
// Backpressure: out_ready=0 holds every output stable and drops in_ready while the entry is full.
//
// Ports:
//   clk, reset                 rising-edge clock, synchronous active-high reset
//   in_valid/in_ready          instruction handshake from IF (in_instr, in_pc)
//   flush                      discard held instruction, accept nothing this cycle
//   out_valid/out_ready        decoded instruction handshake to EX
//   out_op..out_target, out_pc raw instruction fields, extended immediate and PC of the held entry
//   out_wreg, out_regwrite, out_memread, out_memwrite, out_branch, out_jump, out_illegal
//                              decoded destination register and control bits
//
// Build option: define LOAD_USE_INTERLOCK_EN to build the load-use tracker that inserts a
// one-cycle bubble when the held instruction reads the register loaded by the previous LW.
// Without it, EX is responsible for that hazard.
module mips_decode_stage #(
  parameter int PC_W = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [PC_W-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [5:0]      out_op,
  output logic [5:0]      out_funct,
  output logic [4:0]      out_rs,
  output logic [4:0]      out_rt,
  output logic [4:0]      out_rd,
  output logic [15:0]     out_imm,
  output logic [31:0]     out_imm_ext,
  output logic [25:0]     out_target,
  output logic [PC_W-1:0] out_pc,
  output logic [4:0]      out_wreg,
  output logic            out_regwrite,
  output logic            out_memread,
  output logic            out_memwrite,
  output logic            out_branch,
  output logic            out_jump,
  output logic            out_illegal
);

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // R-type function codes
  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_SLT   = 6'b101010;

  // Everything EX sees (except out_valid) lives in one register of this shape.
  typedef struct packed {
    logic [5:0]      op;
    logic [5:0]      funct;
    logic [4:0]      rs;
    logic [4:0]      rt;
    logic [4:0]      rd;
    logic [15:0]     imm;
    logic [31:0]     imm_ext;
    logic [25:0]     target;
    logic [PC_W-1:0] pc;
    logic [4:0]      wreg;
    logic            regwrite;
    logic            memread;
    logic            memwrite;
    logic            branch;
    logic            jump;
    logic            illegal;
  } dec_t;

  dec_t       dec;    // combinational decode of in_instr
  dec_t       q;      // held entry
  logic       vld_q;
  logic       hazard;
  logic       issue;
  logic       accept;
  logic [4:0] wr_dst;

  // ------------------------------------------------------------------
  // Combinational decode of the incoming instruction
  // ------------------------------------------------------------------
  always_comb begin
    dec        = '0;
    wr_dst     = 5'd0;
    dec.op     = in_instr[31:26];
    dec.funct  = in_instr[5:0];
    dec.rs     = in_instr[25:21];
    dec.rt     = in_instr[20:16];
    dec.rd     = in_instr[15:11];
    dec.imm    = in_instr[15:0];
    dec.target = in_instr[25:0];
    dec.pc     = in_pc;

    case (dec.op)
      OP_RTYPE: begin
        case (dec.funct)
          FN_ADDU, FN_SUBU, FN_SLT: wr_dst = dec.rd;
          FN_JR:                    dec.jump = 1'b1;
          default:                  dec.illegal = 1'b1;
        endcase
      end
      OP_BEQ, OP_BNE:          dec.branch = 1'b1;
      OP_ADDIU, OP_ORI, OP_LUI: wr_dst = dec.rt;
      OP_LW: begin
        dec.memread = 1'b1;
        wr_dst      = dec.rt;
      end
      OP_SW:                   dec.memwrite = 1'b1;
      OP_J:                    dec.jump = 1'b1;
      OP_JAL: begin
        dec.jump = 1'b1;
        wr_dst   = 5'd31;
      end
      default:                 dec.illegal = 1'b1;
    endcase

    // A write to $0 is architecturally a no-op, so it is not reported as a write.
    dec.wreg     = wr_dst;
    dec.regwrite = (wr_dst != 5'd0);

    case (dec.op)
      OP_ORI:  dec.imm_ext = {16'h0000, dec.imm};
      OP_LUI:  dec.imm_ext = {dec.imm, 16'h0000};
      default: dec.imm_ext = {{16{dec.imm[15]}}, dec.imm};
    endcase
  end

  // ------------------------------------------------------------------
  // Handshake. out_valid never looks at out_ready; in_ready may.
  // ------------------------------------------------------------------
  assign out_valid = vld_q & ~flush & ~hazard & ~reset;
  assign issue     = out_valid & out_ready;
  assign in_ready  = ~reset & ~flush & (~vld_q | issue);
  assign accept    = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q <= 1'b0;
      q     <= '0;
    end else if (flush) begin
      // Register contents are left as-is; they are meaningless once vld_q drops.
      vld_q <= 1'b0;
    end else if (accept) begin
      // Also covers simultaneous issue+accept: the entry is replaced with no gap.
      q     <= dec;
      vld_q <= 1'b1;
    end else if (issue) begin
      vld_q <= 1'b0;
    end
  end

`ifdef LOAD_USE_INTERLOCK_EN
  // ------------------------------------------------------------------
  // Load-use tracking: remembers the destination of an LW for the one
  // cycle after it issues and stalls a held consumer of that register.
  // ------------------------------------------------------------------
  logic       lu_q;
  logic [4:0] lu_reg;
  logic       rs_used;
  logic       rt_used;

  // Which source fields the held instruction actually reads.
  always_comb begin
    rs_used = 1'b0;
    rt_used = 1'b0;
    case (q.op)
      OP_RTYPE: begin
        case (q.funct)
          FN_ADDU, FN_SUBU, FN_SLT: begin
            rs_used = 1'b1;
            rt_used = 1'b1;
          end
          FN_JR:   rs_used = 1'b1;
          default: ;
        endcase
      end
      OP_BEQ, OP_BNE, OP_SW: begin
        rs_used = 1'b1;
        rt_used = 1'b1;
      end
      OP_ADDIU, OP_ORI, OP_LW: rs_used = 1'b1;
      default: ;
    endcase
  end

  assign hazard = lu_q &
                  ((rs_used & (q.rs != 5'd0) & (q.rs == lu_reg)) |
                   (rt_used & (q.rt != 5'd0) & (q.rt == lu_reg)));

  // lu_q is a one-shot: it never survives more than one cycle, so a bubble
  // is at most one cycle long whether or not the consumer issues.
  always_ff @(posedge clk) begin
    if (reset) begin
      lu_q   <= 1'b0;
      lu_reg <= 5'd0;
    end else begin
      lu_q <= ~flush & issue & q.memread & (q.wreg != 5'd0);
      if (issue & q.memread) begin
        lu_reg <= q.wreg;
      end
    end
  end
`else
  assign hazard = 1'b0;
`endif

  // ------------------------------------------------------------------
  // Outputs straight from the held register
  // ------------------------------------------------------------------
  assign out_op       = q.op;
  assign out_funct    = q.funct;
  assign out_rs       = q.rs;
  assign out_rt       = q.rt;
  assign out_rd       = q.rd;
  assign out_imm      = q.imm;
  assign out_imm_ext  = q.imm_ext;
  assign out_target   = q.target;
  assign out_pc       = q.pc;
  assign out_wreg     = q.wreg;
  assign out_regwrite = q.regwrite;
  assign out_memread  = q.memread;
  assign out_memwrite = q.memwrite;
  assign out_branch   = q.branch;
  assign out_jump     = q.jump;
  assign out_illegal  = q.illegal;

endmodule

// File: tb/tb_mips_decode_stage.sv
// tb_mips_decode_stage: bench for the MIPS decode stage.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
// A mnemonic-level model tracks the held entry and predicts every output each cycle.
module tb_mips_decode_stage;
  localparam int PC_W = 32;

  logic            clk = 1'b0;
  logic            reset, in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0]     in_instr;
  logic [PC_W-1:0] in_pc;
  logic [5:0]      out_op, out_funct;
  logic [4:0]      out_rs, out_rt, out_rd, out_wreg;
  logic [15:0]     out_imm;
  logic [31:0]     out_imm_ext;
  logic [25:0]     out_target;
  logic [PC_W-1:0] out_pc;
  logic            out_regwrite, out_memread, out_memwrite, out_branch, out_jump, out_illegal;

  always #5 clk = ~clk;

  mips_decode_stage #(.PC_W(PC_W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_op(out_op), .out_funct(out_funct), .out_rs(out_rs), .out_rt(out_rt), .out_rd(out_rd),
    .out_imm(out_imm), .out_imm_ext(out_imm_ext), .out_target(out_target), .out_pc(out_pc),
    .out_wreg(out_wreg), .out_regwrite(out_regwrite), .out_memread(out_memread),
    .out_memwrite(out_memwrite), .out_branch(out_branch), .out_jump(out_jump),
    .out_illegal(out_illegal)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  // ------------------------------------------------------------------
  // Reference model: instruction -> mnemonic -> properties
  // ------------------------------------------------------------------
  typedef enum int {M_ADDU, M_SUBU, M_SLT, M_JR, M_BEQ, M_BNE, M_ADDIU, M_ORI,
                    M_LUI, M_LW, M_SW, M_J, M_JAL, M_ILL} mn_t;

  typedef struct packed {
    logic [5:0]  op;
    logic [5:0]  funct;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    logic [31:0] imm_ext;
    logic [25:0] target;
    logic [4:0]  wreg;
    logic        regwrite, memread, memwrite, branch, jump, illegal, use_rs, use_rt;
  } exp_t;

  function automatic mn_t mnem(input logic [31:0] w);
    int op, fn;
    op = int'(w[31:26]);
    fn = int'(w[5:0]);
    if (op == 0) begin
      if (fn == 'h21) return M_ADDU;
      if (fn == 'h23) return M_SUBU;
      if (fn == 'h2A) return M_SLT;
      if (fn == 'h08) return M_JR;
      return M_ILL;
    end
    case (op)
      'h04: return M_BEQ;
      'h05: return M_BNE;
      'h09: return M_ADDIU;
      'h0D: return M_ORI;
      'h0F: return M_LUI;
      'h23: return M_LW;
      'h2B: return M_SW;
      'h02: return M_J;
      'h03: return M_JAL;
      default: return M_ILL;
    endcase
  endfunction

  function automatic exp_t ref_decode(input logic [31:0] w);
    exp_t        e;
    mn_t         m;
    int unsigned iv;
    longint      sv;
    m        = mnem(w);
    e        = '0;
    e.op     = w[31:26];
    e.funct  = w[5:0];
    e.rs     = w[25:21];
    e.rt     = w[20:16];
    e.rd     = w[15:11];
    e.imm    = w[15:0];
    e.target = w[25:0];
    iv       = int'(w[15:0]);
    if (m == M_ORI) e.imm_ext = 32'(iv);
    else if (m == M_LUI) e.imm_ext = 32'(iv * 65536);
    else begin
      sv = (iv >= 32768) ? longint'(iv) - 65536 : longint'(iv);
      e.imm_ext = 32'(sv);
    end
    if (m inside {M_ADDU, M_SUBU, M_SLT}) e.wreg = e.rd;
    else if (m inside {M_ADDIU, M_ORI, M_LUI, M_LW}) e.wreg = e.rt;
    else if (m == M_JAL) e.wreg = 5'd31;
    e.regwrite = (e.wreg != 0);
    e.memread  = (m == M_LW);
    e.memwrite = (m == M_SW);
    e.branch   = (m inside {M_BEQ, M_BNE});
    e.jump     = (m inside {M_J, M_JAL, M_JR});
    e.illegal  = (m == M_ILL);
    e.use_rs   = (m inside {M_ADDU, M_SUBU, M_SLT, M_JR, M_BEQ, M_BNE, M_ADDIU, M_ORI, M_LW, M_SW});
    e.use_rt   = (m inside {M_ADDU, M_SUBU, M_SLT, M_BEQ, M_BNE, M_SW});
    return e;
  endfunction

  // Model state
  logic        m_vld  = 1'b0;
  logic        m_zero = 1'b0;   // register known to be all-zero (after reset)
  logic [31:0] m_instr = '0;
  logic [31:0] m_pc    = '0;
`ifdef LOAD_USE_INTERLOCK_EN
  logic        m_lu     = 1'b0;
  logic [4:0]  m_lu_reg = '0;
`endif
  logic        nx_issue, nx_accept;

  int          iss_cyc[$];
  logic [31:0] iss_pc[$];

  function automatic int find_issue(input logic [31:0] pc);
    foreach (iss_pc[i]) if (iss_pc[i] == pc) return iss_cyc[i];
    return -1;
  endfunction

  task automatic compare();
    exp_t e;
    logic hz, ev, er;
    hz = 1'b0;
`ifdef LOAD_USE_INTERLOCK_EN
    e  = ref_decode(m_instr);
    hz = m_lu && ((e.use_rs && e.rs != 0 && e.rs == m_lu_reg) ||
                  (e.use_rt && e.rt != 0 && e.rt == m_lu_reg));
`endif
    ev = m_vld && !flush && !hz && !reset;
    er = !reset && !flush && (!m_vld || (ev && out_ready));
    chk("out_valid", out_valid, ev);
    chk("in_ready", in_ready, er);
    if (m_vld) begin
      e = ref_decode(m_instr);
      chk("out_op", out_op, e.op);
      chk("out_funct", out_funct, e.funct);
      chk("out_rs", out_rs, e.rs);
      chk("out_rt", out_rt, e.rt);
      chk("out_rd", out_rd, e.rd);
      chk("out_imm", out_imm, e.imm);
      chk("out_imm_ext", out_imm_ext, e.imm_ext);
      chk("out_target", out_target, e.target);
      chk("out_pc", out_pc, m_pc);
      chk("out_wreg", out_wreg, e.wreg);
      chk("ctrl_bits", {out_regwrite, out_memread, out_memwrite, out_branch, out_jump, out_illegal},
          {e.regwrite, e.memread, e.memwrite, e.branch, e.jump, e.illegal});
    end else if (m_zero) begin
      chk("zero_outputs", |{out_op, out_funct, out_rs, out_rt, out_rd, out_imm, out_imm_ext,
                            out_target, out_pc, out_wreg, out_regwrite, out_memread,
                            out_memwrite, out_branch, out_jump, out_illegal}, 1'b0);
    end
    if (out_valid && out_ready) begin
      iss_cyc.push_back(cyc);
      iss_pc.push_back(out_pc);
    end
    nx_issue  = ev && out_ready;
    nx_accept = in_valid && er;
  endtask

  task automatic update_model();
    exp_t e;
    e = ref_decode(m_instr);
    if (reset) begin
      m_vld = 1'b0; m_zero = 1'b1;
`ifdef LOAD_USE_INTERLOCK_EN
      m_lu = 1'b0;
`endif
    end else if (flush) begin
      m_vld = 1'b0; m_zero = 1'b0;
`ifdef LOAD_USE_INTERLOCK_EN
      m_lu = 1'b0;
`endif
    end else begin
`ifdef LOAD_USE_INTERLOCK_EN
      m_lu = nx_issue && e.memread && e.wreg != 0;
      if (m_lu) m_lu_reg = e.wreg;
`endif
      if (nx_accept) begin
        m_instr = in_instr; m_pc = in_pc; m_vld = 1'b1; m_zero = 1'b0;
      end else if (nx_issue) begin
        m_vld = 1'b0;
      end
    end
  endtask

  task automatic drive(input logic rst, input logic fl, input logic iv,
                       input logic [31:0] w, input logic [31:0] pc, input logic ordy);
    reset = rst; flush = fl; in_valid = iv; in_instr = w; in_pc = pc; out_ready = ordy;
    #1;
  endtask

  task automatic tick();
    compare();
    @(posedge clk);
    update_model();
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive(0, 0, 0, 32'h0, 32'h0, 1);
      tick();
    end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [5:0] ops[11];
    logic [5:0] fns[4];
    int k;
    ops = '{6'h00, 6'h00, 6'h04, 6'h05, 6'h09, 6'h0D, 6'h0F, 6'h23, 6'h2B, 6'h02, 6'h03};
    fns = '{6'h21, 6'h23, 6'h2A, 6'h08};
    k = $urandom_range(0, 12);
    if (k >= 11) return $urandom;   // mostly illegal encodings
    return {ops[k], 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 31)),
            (ops[k] == 6'h00) ? fns[$urandom_range(0, 3)] : 6'($urandom_range(0, 63))};
  endfunction

  initial begin
    int t0, rel;
    logic [31:0] w;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b1;
    @(negedge clk);

    // Reset
    drive(1, 0, 0, 32'h0, 32'h0, 1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b0);
    tick(); tick();
    drive(0, 0, 0, 32'h0, 32'h0, 1);
    chk("post_rst_in_ready", in_ready, 1'b1);
    tick();

    // Streaming ADDU $3,$1,$2 then ORI $4,$3,0x8001
    drive(0, 0, 1, 32'h00221821, 32'd100, 1); tick();
    drive(0, 0, 1, 32'h34648001, 32'd104, 1);
    chk("addu_valid", out_valid, 1'b1);
    chk("addu_wreg", out_wreg, 5'd3);
    chk("addu_regwrite", out_regwrite, 1'b1);
    tick();
    drive(0, 0, 0, 32'h0, 32'h0, 1);
    chk("ori_imm_ext", out_imm_ext, 32'h00008001);
    chk("ori_wreg", out_wreg, 5'd4);
    tick();
    idle(1);
    chk("stream_gap", 64'(find_issue(32'd104) - find_issue(32'd100)), 64'(1));

    // Load-use: LW $5,0($1) then ADDU $6,$5,$2
    drive(0, 0, 1, 32'h8C250000, 32'd200, 1); tick();
    drive(0, 0, 1, 32'h00A23021, 32'd204, 1);
    chk("lw_memread", out_memread, 1'b1);
    chk("lw_wreg", out_wreg, 5'd5);
    tick();
    idle(3);
`ifdef LOAD_USE_INTERLOCK_EN
    chk("loaduse_gap", 64'(find_issue(32'd204) - find_issue(32'd200)), 64'(2));
`else
    chk("loaduse_gap", 64'(find_issue(32'd204) - find_issue(32'd200)), 64'(1));
`endif

    // Backpressure with SW $2,4($1) held
    drive(0, 0, 1, 32'hAC220004, 32'd300, 1); tick();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, 32'h00221821, 32'd304, 0);
      chk("bp_valid", out_valid, 1'b1);
      chk("bp_in_ready", in_ready, 1'b0);
      chk("bp_pc", out_pc, 32'd300);
      chk("bp_memwrite", out_memwrite, 1'b1);
      chk("bp_imm_ext", out_imm_ext, 32'h4);
      tick();
    end
    rel = cyc;
    drive(0, 0, 1, 32'h00221821, 32'd304, 1);
    chk("bp_release_in_ready", in_ready, 1'b1);
    tick();
    idle(2);
    chk("bp_issue_cycle", 64'(find_issue(32'd300)), 64'(rel));

    // Flush while BEQ held and a new instruction is offered
    drive(0, 0, 1, 32'h1022FFFF, 32'd400, 0); tick();
    drive(0, 1, 1, 32'h00221821, 32'd404, 1);
    chk("beq_branch", out_branch, 1'b1);
    chk("beq_imm_ext", out_imm_ext, 32'hFFFFFFFF);
    chk("flush_valid", out_valid, 1'b0);
    chk("flush_in_ready", in_ready, 1'b0);
    tick();
    drive(0, 0, 0, 32'h0, 32'h0, 1);
    chk("after_flush_valid", out_valid, 1'b0);
    tick();
    chk("flush_no_issue", 64'(find_issue(32'd400)), 64'(-1));
    chk("flush_no_accept", 64'(find_issue(32'd404)), 64'(-1));

    // Special cases
    drive(0, 0, 1, 32'h0C000010, 32'd600, 1); tick();
    drive(0, 0, 0, 32'h0, 32'h0, 1);
    chk("jal_wreg", out_wreg, 5'd31);
    chk("jal_jump", out_jump, 1'b1);
    chk("jal_target", out_target, 26'h0000010);
    tick();
    drive(0, 0, 1, 32'h3C01ABCD, 32'd604, 1); tick();
    drive(0, 0, 0, 32'h0, 32'h0, 1);
    chk("lui_imm_ext", out_imm_ext, 32'hABCD0000);
    chk("lui_wreg", out_wreg, 5'd1);
    tick();
    drive(0, 0, 1, 32'h00220021, 32'd608, 1); tick();
    drive(0, 0, 0, 32'h0, 32'h0, 1);
    chk("addu_rd0_regwrite", out_regwrite, 1'b0);
    chk("addu_rd0_illegal", out_illegal, 1'b0);
    tick();
    drive(0, 0, 1, 32'hFC000000, 32'd612, 1); tick();
    drive(0, 0, 0, 32'h0, 32'h0, 1);
    chk("op3f_illegal", out_illegal, 1'b1);
    chk("op3f_ctrl", {out_regwrite, out_memread, out_memwrite, out_branch, out_jump}, 5'b0);
    tick();

    // Reset mid-stream with an entry held
    drive(0, 0, 1, 32'h00221821, 32'd500, 0); tick();
    drive(1, 0, 1, 32'h00221821, 32'd504, 1);
    chk("midrst_valid", out_valid, 1'b0);
    chk("midrst_in_ready", in_ready, 1'b0);
    tick();
    drive(0, 0, 0, 32'h0, 32'h0, 1);
    chk("midrst_after_valid", out_valid, 1'b0);
    chk("midrst_wreg", out_wreg, 5'd0);
    chk("midrst_pc", out_pc, 32'd0);
    chk("midrst_regwrite", out_regwrite, 1'b0);
    chk("midrst_in_ready", in_ready, 1'b1);
    tick();

    // Randomized traffic
    t0 = 0;
    for (int n = 0; n < 3000; n++) begin
      t0 = $urandom_range(0, 99);
      w  = rand_instr();
      drive(t0 < 1, (t0 >= 1) && (t0 < 5), $urandom_range(0, 9) < 7, w,
            32'h10000 + 32'(n * 4), $urandom_range(0, 9) < 7);
      tick();
    end
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mips_decode_stage.md
# mips_decode_stage

Registered instruction-decode stage for the 5-stage MIPS pipeline, between IF and EX. Accepts one fetched instruction per cycle over a valid/ready handshake and holds it in a one-entry output register. Presents raw fields, extended immediate and decoded control bits to EX. Supports pipeline flush and an optional one-cycle load-use interlock bubble.

## Interface
- `PC_W`, 32: width of the PC carried with each instruction.
- `clk` in 1: clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `in_valid` in 1: IF presents an instruction.
- `in_ready` out 1: stage accepts this cycle.
- `in_instr` in 32: instruction word.
- `in_pc` in PC_W: PC of `in_instr`.
- `flush` in 1: discard the held instruction; accept nothing this cycle.
- `out_valid` out 1: decoded instruction available to EX.
- `out_ready` in 1: EX accepts.
- `out_op` out 6: opcode, bits 31:26.
- `out_funct` out 6: funct, bits 5:0.
- `out_rs`, `out_rt`, `out_rd` out 5 each: raw bit fields 25:21, 20:16, 15:11.
- `out_imm` out 16: raw bits 15:0.
- `out_imm_ext` out 32: extended immediate.
- `out_target` out 26: raw bits 25:0.
- `out_pc` out PC_W: PC of the held instruction.
- `out_wreg` out 5: destination register; 0 if none.
- `out_regwrite`, `out_memread`, `out_memwrite`, `out_branch`, `out_jump`, `out_illegal` out 1 each: control bits.

## Operation
- Decode table:
  - R-type (op 000000), selected by funct: ADDU 100001, SUBU 100011, SLT 101010, JR 001000.
  - I-type: BEQ 000100, BNE 000101, ADDIU 001001, ORI 001101, LUI 001111, LW 100011, SW 101011.
  - J-type: J 000010, JAL 000011.
- `out_regwrite`/`out_wreg`:
  - ADDU/SUBU/SLT: rd.
  - ADDIU/ORI/LUI/LW: rt.
  - JAL: 31.
  - All other instructions: 0/0.
  - A computed wreg of 0 forces `out_regwrite`=0.
- Memory and control-flow bits:
  - memread for LW only; memwrite for SW only.
  - branch for BEQ/BNE.
  - jump for J, JAL, JR.
- `out_imm_ext`:
  - ORI: zero-extended.
  - LUI: {imm, 16'h0}.
  - All others: sign-extended.
- Any unlisted op or funct: `out_illegal`=1 and all other control bits 0. Raw fields and `out_pc` still pass through.
- Source registers used, for the interlock:
  - rs is read by R-type, BEQ, BNE, ADDIU, ORI, LW, SW.
  - rt is read by ADDU, SUBU, SLT, BEQ, BNE, SW.
- Decode is combinational from `in_instr`. All outputs except `out_valid` come from the output register, loaded on acceptance.
- Occupancy flag `vld_q`.
- Issue = `out_valid & out_ready`.
- `in_ready` = `!reset & !flush & (!vld_q | issue)`.
- Accept = `in_valid & in_ready`; on accept the register loads and `vld_q` is set.
- Issue without accept clears `vld_q`.
- Load-use tracking (`LOAD_USE_INTERLOCK_EN` only):
  - Flag `lu_q` and register `lu_reg`.
  - `lu_q` is set for exactly one cycle after any issue with `out_memread`=1 and `out_wreg`≠0; `lu_reg` captures that `out_wreg`.
  - Hazard = `lu_q` and `lu_reg` equals a used, nonzero rs/rt of the held instruction.
  - `out_valid` = `vld_q & !flush & !hazard`.
  - A bubble therefore lasts exactly one cycle; `lu_q` clears regardless of issue.
- Flush: next edge clears `vld_q` and `lu_q`; register contents are don't-care. Flush overrides a simultaneous accept and issue; neither occurs.

## Timing
- Latency: accept at edge N → `out_valid` from cycle N+1, unless a hazard delays it. Throughput: 1/cycle with `out_ready` held high.
- Back-to-back operation: simultaneous issue and accept replaces the entry at the edge with no gap.
- Backpressure: `out_ready`=0 holds every output stable. `in_ready` stays 0 while full and not issuing.
- Reset, including mid-operation: every output register is 0, `vld_q`=0, `lu_q`=0. `out_valid`=0 and `in_ready`=0 during reset; `in_ready`=1 on the first cycle after.
- Handshake rule: `out_valid` must not depend on `out_ready`. `in_ready` may depend on `out_ready`.

## Configuration
- `LOAD_USE_INTERLOCK_EN` defined: load-use tracking and the one-cycle bubble are built.
- Not defined: tracking logic is absent, `out_valid` = `vld_q & !flush`, and EX is responsible for the hazard.

## Test plan
- Streaming: in_valid=1, out_ready=1, issue ADDU $3,$1,$2 (0x00221821) then ORI $4,$3,0x8001. Required: both issue on consecutive cycles. ADDU gives wreg=3, regwrite=1. ORI gives imm_ext=0x00008001, wreg=4.
- Load-use: LW $5,0($1), then ADDU $6,$5,$2. Required with the macro: one bubble cycle (out_valid=0) between the two issues. Required without the macro: no gap.
- Backpressure: hold out_ready=0 for 3 cycles with a SW held. Required: outputs stable and in_ready=0 throughout; issue on the release cycle.
- Flush: assert flush while BEQ is held and in_valid=1. Required: next cycle out_valid=0, and the presented instruction is not accepted.
- Special cases:
  - JAL 0x0C000010: wreg=31, jump=1, target=0x0000010.
  - LUI 0x3C01ABCD: imm_ext=0xABCD0000.
  - ADDU with rd=0: regwrite=0.
  - op 111111: illegal=1.
- Reset mid-stream: assert reset with vld_q=1. Required: next cycle out_valid=0 and all outputs 0; in_ready=1 the cycle after reset drops.
